// File: rtl/gps_pkg.sv
// Shared constants and types for the GPS sequencer/generator slice.
package gps_pkg;

    localparam int CHIPS_PER_CODE = 1023;
    localparam int CODES_PER_BIT  = 20;
    localparam int WORD_BITS      = 30;

    localparam logic [7:0] TLM_PREAMBLE = 8'h8B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/gps_msg_buffer.sv
// Navigation word double buffer: ready/valid holding register feeding an
// MSB-first shift register, with PRESET_WORD substitution on underrun.
module gps_msg_buffer
    import gps_pkg::*;
#(
    parameter logic [WORD_BITS-1:0] PRESET_WORD = 30'h22C0_0000
) (
    input  logic                 clk_in,
    input  logic                 rst_in_n,
    input  logic                 load_start_in,
    input  logic                 bit_edge_in,
    input  logic                 word_edge_in,
    input  logic [WORD_BITS-1:0] msg_word_in,
    input  logic                 msg_valid_in,
    output logic                 msg_ready_out,
    output logic                 msg_bit_out,
    output logic                 underrun_out
);

    logic [WORD_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 underrun_q, underrun_d;
    logic                 xfer;
    logic                 consume;

    assign xfer    = msg_valid_in && !hold_full_q;
    assign consume = load_start_in || word_edge_in;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        underrun_d  = underrun_q;

        // A consume always sees the old holding content; a load in the same
        // cycle refills the holding register so ready stays low.
        if (consume) begin
            shift_d     = hold_full_q ? hold_q : PRESET_WORD;
            hold_full_d = 1'b0;
            if (load_start_in) begin
                underrun_d = 1'b0;
            end else if (!hold_full_q) begin
                underrun_d = 1'b1;
            end
        end else if (bit_edge_in) begin
            shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
        end

        if (xfer) begin
            hold_d      = msg_word_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            underrun_q  <= underrun_d;
        end
    end

    assign msg_ready_out = !hold_full_q;
    assign msg_bit_out   = shift_q[WORD_BITS-1];
    assign underrun_out  = underrun_q;

endmodule

// File: rtl/gps_chip_sequencer.sv
// Phase-alignment FSM and chip/epoch/bit/word counter chain driving gps_gen_core,
// with the navigation message serialiser attached.
module gps_chip_sequencer #(
    parameter int          CLK_DIV        = 16,
    parameter int          CHIPS_PER_CODE = gps_pkg::CHIPS_PER_CODE,
    parameter int          CODES_PER_BIT  = gps_pkg::CODES_PER_BIT,
    parameter logic [29:0] PRESET_WORD    = 30'h22C0_0000
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic        code_phase_done_in,
    input  logic [29:0] msg_word_in,
    input  logic        msg_valid_in,
    output logic        msg_ready_out,
    output logic        ca_phase_start_out,
    output logic        chip_ena_out,
    output logic        msg_bit_out,
    output logic        epoch_out,
    output logic        bit_edge_out,
    output logic        word_edge_out,
    output logic        underrun_out,
    output logic        busy_out
);

    import gps_pkg::seq_state_e;
    import gps_pkg::ST_IDLE;
    import gps_pkg::ST_PHASE;
    import gps_pkg::ST_RUN;
    import gps_pkg::WORD_BITS;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [9:0] CHIP_LAST = 10'(CHIPS_PER_CODE - 1);
    localparam logic [4:0] CODE_LAST = 5'(CODES_PER_BIT - 1);
    localparam logic [4:0] BIT_LAST  = 5'(WORD_BITS - 1);

    seq_state_e  state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  chip_cnt_q, chip_cnt_d;
    logic [4:0]  code_cnt_q, code_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        chip_ena_q, chip_ena_d;
    logic        epoch_q, epoch_d;
    logic        bit_edge_q, bit_edge_d;
    logic        word_edge_q, word_edge_d;

    logic        run;
    logic        chip_tick;
    logic        epoch_tick;
    logic        bit_tick;
    logic        word_tick;
    logic        start_go;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        chip_cnt_d = chip_cnt_q;
        code_cnt_d = code_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        start_go   = 1'b0;

        // Ticks fire on the divider wrap; the registered pulses below land in
        // the same cycle the counters advance, keeping all edges coincident.
        run        = (state_q == ST_RUN);
        chip_tick  = run && (div_cnt_q == DIV_LAST) && !stop_in;
        epoch_tick = chip_tick && (chip_cnt_q == CHIP_LAST);
        bit_tick   = epoch_tick && (code_cnt_q == CODE_LAST);
        word_tick  = bit_tick && (bit_cnt_q == BIT_LAST);

        if (stop_in) begin
            state_d    = ST_IDLE;
            div_cnt_d  = '0;
            chip_cnt_d = '0;
            code_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    div_cnt_d  = '0;
                    chip_cnt_d = '0;
                    code_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (start_in) begin
                        state_d  = ST_PHASE;
                        start_go = 1'b1;
                    end
                end
                ST_PHASE: begin
                    if (code_phase_done_in) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    div_cnt_d = chip_tick ? '0 : div_cnt_q + 8'd1;
                    if (chip_tick) begin
                        chip_cnt_d = epoch_tick ? '0 : chip_cnt_q + 10'd1;
                    end
                    if (epoch_tick) begin
                        code_cnt_d = bit_tick ? '0 : code_cnt_q + 5'd1;
                    end
                    if (bit_tick) begin
                        bit_cnt_d = word_tick ? '0 : bit_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        chip_ena_d  = chip_tick;
        epoch_d     = epoch_tick;
        bit_edge_d  = bit_tick;
        word_edge_d = word_tick;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            chip_cnt_q  <= '0;
            code_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            chip_ena_q  <= 1'b0;
            epoch_q     <= 1'b0;
            bit_edge_q  <= 1'b0;
            word_edge_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            chip_cnt_q  <= chip_cnt_d;
            code_cnt_q  <= code_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            chip_ena_q  <= chip_ena_d;
            epoch_q     <= epoch_d;
            bit_edge_q  <= bit_edge_d;
            word_edge_q <= word_edge_d;
        end
    end

    assign ca_phase_start_out = (state_q == ST_PHASE);
    assign busy_out           = (state_q != ST_IDLE);
    assign chip_ena_out       = chip_ena_q;
    assign epoch_out          = epoch_q;
    assign bit_edge_out       = bit_edge_q;
    assign word_edge_out      = word_edge_q;

    // Shifting follows the registered bit edge, so msg_bit_out moves one
    // cycle after bit_edge_out is seen by the core.
    gps_msg_buffer #(
        .PRESET_WORD (PRESET_WORD)
    ) u_msg_buffer (
        .clk_in        (clk_in),
        .rst_in_n      (rst_in_n),
        .load_start_in (start_go),
        .bit_edge_in   (bit_edge_q),
        .word_edge_in  (word_edge_q),
        .msg_word_in   (msg_word_in),
        .msg_valid_in  (msg_valid_in),
        .msg_ready_out (msg_ready_out),
        .msg_bit_out   (msg_bit_out),
        .underrun_out  (underrun_out)
    );

endmodule

// File: tb/tb_gps_chip_sequencer.sv
// Randomised bench: a small-parameter instance checked every cycle against a
// timing/message model, plus a full-length code instance for the counter chain.
`timescale 1ns/1ps
module tb_gps_chip_sequencer;

    localparam int DIV = 4;
    localparam int CPC = 3;
    localparam int CPB = 2;
    localparam int WB  = 30;
    localparam logic [29:0] PRESET = 30'h22C0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, b_rst_n;
    logic        s_start, s_stop, s_done, s_valid;
    logic [29:0] s_word;
    logic        s_ready, s_phase, s_chip, s_bit, s_epoch, s_bedge, s_wedge, s_under, s_busy;
    logic        b_start, b_stop, b_done, b_valid;
    logic [29:0] b_word;
    logic        b_ready, b_phase, b_chip, b_bit, b_epoch, b_bedge, b_wedge, b_under, b_busy;
    logic [8:0]  obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: spec-level state, cycles since RUN entry, buffer contents.
    int          m_st;
    int          m_r;
    logic        m_full;
    logic [29:0] m_hold;
    logic [29:0] m_word;
    int          m_sh;
    logic        m_under;

    gps_chip_sequencer #(
        .CLK_DIV        (DIV),
        .CHIPS_PER_CODE (CPC),
        .CODES_PER_BIT  (CPB),
        .PRESET_WORD    (PRESET)
    ) dut (
        .clk_in             (clk),
        .rst_in_n           (rst_n),
        .start_in           (s_start),
        .stop_in            (s_stop),
        .code_phase_done_in (s_done),
        .msg_word_in        (s_word),
        .msg_valid_in       (s_valid),
        .msg_ready_out      (s_ready),
        .ca_phase_start_out (s_phase),
        .chip_ena_out       (s_chip),
        .msg_bit_out        (s_bit),
        .epoch_out          (s_epoch),
        .bit_edge_out       (s_bedge),
        .word_edge_out      (s_wedge),
        .underrun_out       (s_under),
        .busy_out           (s_busy)
    );

    gps_chip_sequencer #(
        .CLK_DIV (2)
    ) dut_big (
        .clk_in             (clk),
        .rst_in_n           (b_rst_n),
        .start_in           (b_start),
        .stop_in            (b_stop),
        .code_phase_done_in (b_done),
        .msg_word_in        (b_word),
        .msg_valid_in       (b_valid),
        .msg_ready_out      (b_ready),
        .ca_phase_start_out (b_phase),
        .chip_ena_out       (b_chip),
        .msg_bit_out        (b_bit),
        .epoch_out          (b_epoch),
        .bit_edge_out       (b_bedge),
        .word_edge_out      (b_wedge),
        .underrun_out       (b_under),
        .busy_out           (b_busy)
    );

    assign obs = {s_ready, s_phase, s_chip, s_bit, s_epoch, s_bedge, s_wedge, s_under, s_busy};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_r     = 0;
        m_full  = 1'b0;
        m_hold  = '0;
        m_word  = '0;
        m_sh    = 0;
        m_under = 1'b0;
    endtask

    // Expected outputs from elapsed RUN time: chip k (k>=1) lands k*DIV cycles
    // after RUN entry; epochs, bits and words are multiples of chips.
    function automatic logic [8:0] exp_vec();
        int          k;
        logic        run, chip, ep, be, we, mb;
        logic [29:0] t;
        run  = (m_st == 2);
        k    = m_r / DIV;
        chip = run && (m_r >= DIV) && ((m_r % DIV) == 0);
        ep   = chip && ((k % CPC) == 0);
        be   = chip && ((k % (CPC * CPB)) == 0);
        we   = chip && ((k % (CPC * CPB * WB)) == 0);
        t    = m_word << m_sh;
        mb   = (m_sh < WB) ? t[29] : 1'b0;
        return {!m_full, (m_st == 1), chip, mb, ep, be, we, m_under, (m_st != 0)};
    endfunction

    task automatic cyc(input logic st, input logic sp, input logic dn, input logic vl,
                       input logic [29:0] w);
        logic [8:0] ev;
        logic       xfer, cons_start;
        @(negedge clk);
        ev = exp_vec();
        check_eq("outputs", {23'd0, obs}, {23'd0, ev});
        s_start = st;
        s_stop  = sp;
        s_done  = dn;
        s_valid = vl;
        s_word  = w;
        xfer       = vl && !m_full;
        cons_start = (m_st == 0) && st && !sp;
        if (cons_start || ev[2]) begin
            m_word = m_full ? m_hold : PRESET;
            if (cons_start) m_under = 1'b0;
            else if (!m_full) m_under = 1'b1;
            m_sh   = 0;
            m_full = 1'b0;
        end else if (ev[3]) begin
            m_sh++;
        end
        if (xfer) begin
            m_hold = w;
            m_full = 1'b1;
            $display("[TB] load word %h", w);
        end
        if (sp) begin
            m_st = 0;
            m_r  = 0;
        end else begin
            case (m_st)
                0: if (st) m_st = 1;
                1: if (dn) begin m_st = 2; m_r = 0; end
                default: m_r++;
            endcase
        end
    endtask

    task automatic run_n(input int n, input int vrate, input int srate);
        for (int i = 0; i < n; i++) begin
            cyc(($urandom_range(99) < srate), 1'b0, 1'b1,
                ($urandom_range(99) < vrate), 30'($urandom));
        end
    endtask

    task automatic first_chip_check(input string tag, input int vrate);
        int first;
        first = -1;
        for (int i = 0; i <= 2 * DIV; i++) begin
            cyc(1'b0, 1'b0, 1'b1, ($urandom_range(99) < vrate), 30'($urandom));
            if (i == 0) check_eq({tag, "_phase_low"}, 32'(s_phase), 32'd0);
            if (s_chip && first < 0) first = i;
        end
        check_eq(tag, first, DIV);
    endtask

    task automatic small_seq();
        int pc;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        check_eq("reset_ready", 32'(s_ready), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h2AAA_AAAA);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        check_eq("ready_after_load", 32'(s_ready), 32'd0);

        // Phase handshake: done held low for 50 cycles, then high.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 30'd0);
        pc = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
            if (s_phase) pc++;
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        if (s_phase) pc++;
        check_eq("phase_cycles", pc, 51);
        check_eq("busy_in_phase", 32'(s_busy), 32'd1);
        first_chip_check("first_chip", 100);

        // Continuous valid across several word edges, then starve the buffer.
        run_n(3 * 720, 100, 2);
        check_eq("no_underrun_cont", 32'(s_under), 32'd0);
        run_n(1500, 0, 0);
        check_eq("underrun_set", 32'(s_under), 32'd1);
        run_n(900, 3, 2);
        check_eq("underrun_sticky", 32'(s_under), 32'd1);

        // Stop mid-run, stop-over-start priority, restart with done already high.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 30'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        check_eq("stop_busy", 32'(s_busy), 32'd0);
        check_eq("stop_chip", 32'(s_chip), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 30'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        check_eq("stop_beats_start", 32'(s_busy), 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 30'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        check_eq("underrun_cleared", 32'(s_under), 32'd0);
        first_chip_check("restart_first_chip", 25);
        run_n(800, 25, 2);

        // Stop during PHASE wins over done; then restart with random done delay.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 30'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 30'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 30'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 30'd0);
        check_eq("stop_in_phase", 32'(s_busy), 32'd0);
        for (int i = 0; i < int'($urandom_range(6)); i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'($urandom));
        run_n(300, 30, 2);

        // Asynchronous reset mid-run.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", {23'd0, obs}, {23'd0, 9'b1_0000_0000});
        model_reset();
        s_start = 1'b0;
        s_stop  = 1'b0;
        s_done  = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 30'd0);
        run_n(200, 50, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
    endtask

    task automatic big_seq();
        int guard, nchip, nep, nbe, nwe, be_ep, be_coinc, firstc;
        nchip = 0; nep = 0; nbe = 0; nwe = 0; be_ep = -1; be_coinc = 0; firstc = -1;
        @(negedge clk);
        b_start = 1'b1;
        b_done  = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        guard = 0;
        while (!(b_busy && !b_phase) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("big_run_entry", 32'(guard < 20), 32'd1);
        for (int r = 1; r <= 2 * 1023 * 20; r++) begin
            @(negedge clk);
            if (b_chip) nchip++;
            if (b_chip && firstc < 0) firstc = r;
            if (b_epoch) nep++;
            if (b_wedge) nwe++;
            if (b_bedge) begin
                nbe++;
                be_ep = nep;
                be_coinc = int'(b_epoch && b_chip);
            end
        end
        check_eq("big_chip_count", nchip, 20460);
        check_eq("big_epoch_count", nep, 20);
        check_eq("big_bit_edges", nbe, 1);
        check_eq("big_bit_at_epoch", be_ep, 20);
        check_eq("big_bit_coincident", be_coinc, 1);
        check_eq("big_word_edges", nwe, 0);
        check_eq("big_first_chip", firstc, 2);
        check_eq("big_msg_bit", 32'(b_bit), 32'(PRESET[29]));
        check_eq("big_underrun", 32'(b_under), 32'd0);
        check_eq("big_ready", 32'(b_ready), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        b_rst_n = 1'b0;
        s_start = 1'b0; s_stop = 1'b0; s_done = 1'b0; s_valid = 1'b0; s_word = '0;
        b_start = 1'b0; b_stop = 1'b0; b_done = 1'b0; b_valid = 1'b0; b_word = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        b_rst_n = 1'b1;
        fork
            small_seq();
            big_seq();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
